// File: rtl/osd_di_packet_arbiter_pkg.sv
// Shared types for the DI packet arbiter: the DI flit layout and the arbiter FSM states.
package osd_di_packet_arbiter_pkg;

    // One DI flit: {data[15:0], last, valid}, so valid sits in bit 0.
    typedef struct packed {
        logic [15:0] data;
        logic        last;
        logic        valid;
    } dii_flit;

    // IDLE picks the next packet owner; BUSY forwards that owner's flits until last=1.
    typedef enum logic [0:0] {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } di_arb_state_t;

endpackage

// File: rtl/osd_rr_arbiter.sv
// Combinational round-robin picker: scans the requests starting one slot after ptr
// and returns the first requester as a one-hot grant and as a binary index.
// The pointer register lives in the parent so it only advances when a grant is taken.
module osd_rr_arbiter #(
    parameter int N     = 2,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] gnt_idx
);

    logic             found;
    logic [IDX_W:0]   cand;

    // Walk ptr+1 .. ptr+N (mod N) and latch onto the first active request.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 1; off <= N; off++) begin
            cand = {1'b0, ptr} + (IDX_W+1)'(off);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if (!found && req[cand[IDX_W-1:0]]) begin
                found                  = 1'b1;
                gnt[cand[IDX_W-1:0]]   = 1'b1;
                gnt_idx                = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/osd_di_packet_arbiter.sv
// Packet-level arbiter merging N DI input links onto one registered DI output link.
// A grant is held from the first flit of a packet through the flit with last=1, so
// packets never interleave. Optional per-input packet counters are built only when
// the macro OSD_DI_ARB_STATS_EN is defined; arbitration is the same either way.
module osd_di_packet_arbiter
    import osd_di_packet_arbiter_pkg::*;
#(
    parameter int N     = 2,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  dii_flit              in [N],
    output logic [N-1:0]         in_ready,
    output dii_flit              out,
    input  logic                 out_ready
`ifdef OSD_DI_ARB_STATS_EN
    ,
    output logic [CNT_W-1:0]     pkt_cnt [N]
`endif
);

    localparam int IDX_W = $clog2(N);

    di_arb_state_t     state;
    di_arb_state_t     next_state;
    logic [IDX_W-1:0]  grant;
    logic [IDX_W-1:0]  rr_ptr;
    logic [N-1:0]      req;
    logic [N-1:0]      rr_gnt;
    logic [IDX_W-1:0]  rr_gnt_idx;
    logic              any_req;
    logic              accept;

    // Gather the per-input valid bits as the arbitration request vector.
    always_comb begin
        req = '0;
        for (int i = 0; i < N; i++) begin
            req[i] = in[i].valid;
        end
    end

    osd_rr_arbiter #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_rr (
        .req     (req),
        .ptr     (rr_ptr),
        .gnt     (rr_gnt),
        .gnt_idx (rr_gnt_idx)
    );

    assign any_req = |rr_gnt;

    // Next-state and handshake decode: only the granted input sees ready, and only in BUSY.
    always_comb begin
        next_state = state;
        in_ready   = '0;
        accept     = 1'b0;
        case (state)
            ARB_IDLE: begin
                if (any_req) begin
                    next_state = ARB_BUSY;
                end
            end
            ARB_BUSY: begin
                in_ready[grant] = !out.valid || out_ready;
                accept          = in[grant].valid && in_ready[grant];
                if (accept && in[grant].last) begin
                    next_state = ARB_IDLE;
                end
            end
            default: begin
                next_state = ARB_IDLE;
            end
        endcase
    end

    // State register plus grant/pointer capture when a new packet owner is chosen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= ARB_IDLE;
            grant  <= '0;
            rr_ptr <= IDX_W'(N - 1);
        end else begin
            state <= next_state;
            if (state == ARB_IDLE && any_req) begin
                grant  <= rr_gnt_idx;
                rr_ptr <= rr_gnt_idx;
            end
        end
    end

    // Output register: load accepted flits, retire the current one once downstream takes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out <= '0;
        end else if (accept) begin
            out <= in[grant];
        end else if (out.valid && out_ready) begin
            out.valid <= 1'b0;
        end
    end

`ifdef OSD_DI_ARB_STATS_EN
    // Count forwarded packets per input on each accepted last flit; counters wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < N; i++) begin
                pkt_cnt[i] <= '0;
            end
        end else if (accept && in[grant].last) begin
            pkt_cnt[grant] <= pkt_cnt[grant] + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_osd_di_packet_arbiter.sv
// Directed bench for osd_di_packet_arbiter with N=2 and CNT_W=2 (the narrow counter
// makes wrap-around reachable). Packet counter checks exist only when
// OSD_DI_ARB_STATS_EN is defined.
module tb_osd_di_packet_arbiter;
    import osd_di_packet_arbiter_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        out_ready = 1'b1;
    dii_flit     in0_s = '0;
    dii_flit     in1_s = '0;
    dii_flit     in_arr [2];
    logic [1:0]  in_ready;
    dii_flit     out_f;
`ifdef OSD_DI_ARB_STATS_EN
    logic [1:0]  pkt_cnt [2];
`endif

    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          rise_cyc0 = 0;
    bit          hs0 = 1'b0;
    bit          hs1 = 1'b0;
    dii_flit     q0 [$];
    dii_flit     q1 [$];
    dii_flit     obs [$];
    int          obs_cyc [$];

    assign in_arr[0] = in0_s;
    assign in_arr[1] = in1_s;

    osd_di_packet_arbiter #(
        .N     (2),
        .CNT_W (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in        (in_arr),
        .in_ready  (in_ready),
        .out       (out_f),
        .out_ready (out_ready)
`ifdef OSD_DI_ARB_STATS_EN
        ,
        .pkt_cnt   (pkt_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Source 0: present queue head at negedge, note handshake just before the posedge.
    initial begin
        forever begin
            @(negedge clk);
            if (hs0 && q0.size() > 0) q0.delete(0);
            hs0 = 1'b0;
            if (q0.size() > 0) begin
                if (!in0_s.valid) rise_cyc0 = cyc;
                in0_s = q0[0];
            end else begin
                in0_s = '0;
            end
            #3;
            hs0 = rst_n && in0_s.valid && in_ready[0];
        end
    end

    // Source 1: same behaviour as source 0.
    initial begin
        forever begin
            @(negedge clk);
            if (hs1 && q1.size() > 0) q1.delete(0);
            hs1 = 1'b0;
            if (q1.size() > 0) begin
                in1_s = q1[0];
            end else begin
                in1_s = '0;
            end
            #3;
            hs1 = rst_n && in1_s.valid && in_ready[1];
        end
    end

    // Output monitor: log every flit the downstream consumes, with its cycle stamp.
    initial begin
        forever begin
            @(negedge clk);
            #3;
            if (rst_n && out_f.valid && out_ready) begin
                obs.push_back(out_f);
                obs_cyc.push_back(cyc);
            end
        end
    end

    task automatic push_pkt(input int src, input int nfl, input logic [15:0] base);
        dii_flit f;
        for (int k = 0; k < nfl; k++) begin
            f.data  = base + 16'(k);
            f.last  = (k == nfl - 1);
            f.valid = 1'b1;
            if (src == 0) q0.push_back(f);
            else          q1.push_back(f);
        end
    endtask

    task automatic flush();
        q0.delete();
        q1.delete();
        hs0 = 1'b0;
        hs1 = 1'b0;
        obs.delete();
        obs_cyc.delete();
        out_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        flush();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic wait_obs(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk); #4;
            if (obs.size() >= n) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (out_f.valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_valid got=%b want=0", out_f.valid); end
        total++; if (out_f.data !== 16'h0) begin bad++; $display("[TB] FAIL reset_data got=%h want=0000", out_f.data); end
        total++; if (out_f.last !== 1'b0) begin bad++; $display("[TB] FAIL reset_last got=%b want=0", out_f.last); end
        total++; if (in_ready !== 2'b00) begin bad++; $display("[TB] FAIL reset_in_ready got=%b want=00", in_ready); end
`ifdef OSD_DI_ARB_STATS_EN
        total++; if (pkt_cnt[0] !== 2'd0 || pkt_cnt[1] !== 2'd0) begin bad++; $display("[TB] FAIL reset_pkt_cnt got=%0d,%0d want=0,0", pkt_cnt[0], pkt_cnt[1]); end
`endif
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_single_packet();
        bit ok;
        logic [15:0] exp_d [3];
        do_reset();
        exp_d[0] = 16'h1111; exp_d[1] = 16'h2222; exp_d[2] = 16'h3333;
        for (int k = 0; k < 3; k++) begin
            dii_flit f;
            f.data = exp_d[k]; f.last = (k == 2); f.valid = 1'b1;
            q0.push_back(f);
        end
        wait_obs(3, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL single_timeout got=%0d flits want=3", obs.size()); return; end
        for (int k = 0; k < 3; k++) begin
            total++; if (obs[k].data !== exp_d[k] || obs[k].last !== (k == 2)) begin
                bad++; $display("[TB] FAIL single_flit%0d got=%h/%b want=%h/%b", k, obs[k].data, obs[k].last, exp_d[k], (k == 2));
            end
        end
        total++; if (obs_cyc[0] - rise_cyc0 !== 2) begin bad++; $display("[TB] FAIL single_latency got=%0d want=2", obs_cyc[0] - rise_cyc0); end
        total++; if (obs_cyc[1] - obs_cyc[0] !== 1 || obs_cyc[2] - obs_cyc[1] !== 1) begin
            bad++; $display("[TB] FAIL single_consecutive got=%0d,%0d want=1,1", obs_cyc[1] - obs_cyc[0], obs_cyc[2] - obs_cyc[1]);
        end
    endtask

    task automatic test_simultaneous();
        bit ok;
        logic [15:0] exp_d [4];
        do_reset();
        push_pkt(0, 2, 16'h0A00);
        push_pkt(1, 2, 16'h1B00);
        exp_d[0] = 16'h0A00; exp_d[1] = 16'h0A01; exp_d[2] = 16'h1B00; exp_d[3] = 16'h1B01;
        wait_obs(4, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL simul_timeout got=%0d flits want=4", obs.size()); return; end
        for (int k = 0; k < 4; k++) begin
            total++; if (obs[k].data !== exp_d[k]) begin bad++; $display("[TB] FAIL simul_order%0d got=%h want=%h", k, obs[k].data, exp_d[k]); end
        end
        total++; if (obs_cyc[2] - obs_cyc[1] !== 2) begin bad++; $display("[TB] FAIL simul_bubble got=%0d want=2", obs_cyc[2] - obs_cyc[1]); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        do_reset();
        for (int p = 0; p < 4; p++) begin
            push_pkt(0, 2, 16'h0000 | 16'(p << 4));
            push_pkt(1, 2, 16'h1000 | 16'(p << 4));
        end
        wait_obs(16, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL b2b_timeout got=%0d flits want=16", obs.size()); return; end
        for (int k = 0; k < 8; k++) begin
            logic [15:0] want;
            want = 16'((k % 2) << 12) | 16'((k / 2) << 4);
            total++; if (obs[2*k].data !== want || obs[2*k+1].data !== want + 16'd1) begin
                bad++; $display("[TB] FAIL b2b_pkt%0d got=%h,%h want=%h,%h", k, obs[2*k].data, obs[2*k+1].data, want, want + 16'd1);
            end
        end
    endtask

    task automatic test_backpressure();
        bit ok;
        do_reset();
        push_pkt(0, 4, 16'h4001);
        wait_obs(2, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL bp_start_timeout got=%0d flits want=2", obs.size()); return; end
        @(negedge clk);
        out_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            #2;
            total++; if (out_f.valid !== 1'b1 || out_f.data !== 16'h4003) begin
                bad++; $display("[TB] FAIL bp_hold%0d got=%b/%h want=1/4003", c, out_f.valid, out_f.data);
            end
            total++; if (in_ready[0] !== 1'b0) begin bad++; $display("[TB] FAIL bp_in_ready%0d got=%b want=0", c, in_ready[0]); end
            @(negedge clk);
        end
        out_ready = 1'b1;
        wait_obs(4, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL bp_end_timeout got=%0d flits want=4", obs.size()); return; end
        repeat (5) @(negedge clk);
        total++; if (obs.size() !== 4) begin bad++; $display("[TB] FAIL bp_count got=%0d want=4", obs.size()); end
        for (int k = 0; k < 4; k++) begin
            total++; if (obs[k].data !== 16'h4001 + 16'(k)) begin bad++; $display("[TB] FAIL bp_flit%0d got=%h want=%h", k, obs[k].data, 16'h4001 + 16'(k)); end
        end
    endtask

    task automatic test_reset_mid_packet();
        bit ok;
        logic [15:0] exp_d [4];
        do_reset();
        push_pkt(0, 4, 16'h5001);
        wait_obs(2, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL rstmid_timeout got=%0d flits want=2", obs.size()); return; end
        @(posedge clk); #1;
        rst_n = 1'b0;
        flush();
        #1;
        total++; if (out_f.valid !== 1'b0) begin bad++; $display("[TB] FAIL rstmid_valid got=%b want=0", out_f.valid); end
        total++; if (in_ready !== 2'b00) begin bad++; $display("[TB] FAIL rstmid_in_ready got=%b want=00", in_ready); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        push_pkt(0, 2, 16'h6001);
        push_pkt(1, 2, 16'h7001);
        exp_d[0] = 16'h6001; exp_d[1] = 16'h6002; exp_d[2] = 16'h7001; exp_d[3] = 16'h7002;
        wait_obs(4, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL rstmid_after_timeout got=%0d flits want=4", obs.size()); return; end
        for (int k = 0; k < 4; k++) begin
            total++; if (obs[k].data !== exp_d[k]) begin bad++; $display("[TB] FAIL rstmid_order%0d got=%h want=%h", k, obs[k].data, exp_d[k]); end
        end
    endtask

`ifdef OSD_DI_ARB_STATS_EN
    task automatic test_stats();
        bit ok;
        do_reset();
        for (int p = 0; p < 3; p++) push_pkt(1, 2, 16'h8000 | 16'(p << 4));
        push_pkt(0, 2, 16'h9000);
        wait_obs(8, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL stats_timeout got=%0d flits want=8", obs.size()); return; end
        repeat (3) @(negedge clk);
        total++; if (pkt_cnt[1] !== 2'd3) begin bad++; $display("[TB] FAIL stats_cnt1 got=%0d want=3", pkt_cnt[1]); end
        total++; if (pkt_cnt[0] !== 2'd1) begin bad++; $display("[TB] FAIL stats_cnt0 got=%0d want=1", pkt_cnt[0]); end
        for (int p = 0; p < 4; p++) push_pkt(0, 1, 16'hA000 | 16'(p));
        wait_obs(12, ok);
        total++; if (!ok) begin bad++; $display("[TB] FAIL stats_wrap_timeout got=%0d flits want=12", obs.size()); return; end
        repeat (3) @(negedge clk);
        total++; if (pkt_cnt[0] !== 2'd1) begin bad++; $display("[TB] FAIL stats_wrap got=%0d want=1", pkt_cnt[0]); end
        total++; if (pkt_cnt[1] !== 2'd3) begin bad++; $display("[TB] FAIL stats_cnt1_after got=%0d want=3", pkt_cnt[1]); end
    endtask
`endif

    initial begin
        $display("[TB] starting osd_di_packet_arbiter bench");
        test_reset();
        test_single_packet();
        test_simultaneous();
        test_back_to_back();
        test_backpressure();
        test_reset_mid_packet();
`ifdef OSD_DI_ARB_STATS_EN
        test_stats();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
